sound_sequencer: RTL and testbench
==================================

Name: sound_sequencer

Overview:
- CPU-facing controller for the 4-channel sound generator; owns each channel's period, volume and width configuration.
- Accepts single-cycle register writes and drives per-channel note durations from a shared tick prescaler.
- Walks the channels with a round-robin scanner that uses one shared decrement datapath; no per-channel arithmetic.
- Sits between the CPU I/O decode and the sound generator; its outputs replace the generator's static initial values.

Parameters:
- TICK_DIV, 800, clk cycles per sequencer tick; legal values 8..65535.
- NUM_CH, 4, number of channels; fixed at 4 (address decode depends on it).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- wr_en, in, 1, register write strobe; one write per asserted cycle.
- addr, in, 4, [3:2] = channel, [1:0] = register (0 period, 1 volume, 2 width, 3 duration).
- wr_data, in, 16, write data.
- done_clr, in, 4, per-channel sticky done clear.
- period_out, out, 64, channel n period at [16n+15:16n].
- volume_out, out, 20, channel n volume at [5n+4:5n].
- width_out, out, 12, channel n width at [3n+2:3n].
- done, out, 4, sticky note-expired flags.
- busy, out, 1, high while a tick scan is in progress.

Behaviour:
- Reset values: period = 14205 (16'h377D), volume = 0, width = 3, duration = 0, decay fields = 0, done = 0, busy = 0. Prescaler and scanner both clear.
- Write decode: addr[1:0] selects the register.
  - 0: period = wr_data.
  - 1: volume = wr_data[4:0]; decay_rate = wr_data[12:8]; the channel's decay counter is reloaded.
  - 2: width = wr_data[2:0].
  - 3: duration = wr_data; done[ch] is cleared.
- Write latency: every write is visible on its output one cycle after wr_en.
- Prescaler: counts 0..TICK_DIV-1; tick pulses for one cycle on wrap.
- Scanner states:
  - IDLE to SCAN0 on tick.
  - SCANn to SCAN(n+1); SCAN3 to IDLE.
  - busy = 1 in SCAN0..SCAN3.
  - TICK_DIV >= 8 guarantees a scan finishes before the next tick.
- SCANn, duration handling:
  - duration == 0 means sustain; the counter is untouched.
  - duration == 1: duration becomes 0, volume is forced to 0, done[n] is set.
  - Otherwise duration decrements by 1.
- Write and scan hitting the same channel in the same cycle: the write wins. For the written register, the scan's update to that channel is discarded. Other registers on that channel still take the scan result.
- Precedence on done[n] is set over done_clr in the same cycle, except a duration write, which always clears it.
- Width rules: all arithmetic is unsigned. Decrements never wrap below 0.
- Reset mid-scan returns to IDLE next cycle with all reset values applied.

Optional Feature:
- Macro: SOUND_ENVELOPE_EN.
- Defined:
  - In each SCANn with decay_rate != 0, the channel's decay counter decrements.
  - When the counter reaches 0 it reloads decay_rate and volume decrements by 1, saturating at 0.
  - This shares the scanner's decrement datapath, one channel per cycle.
- Undefined:
  - decay_rate is stored, but it has no effect.
  - Volume changes only on writes and on duration expiry.

Decomposition:
- Package sound_pkg holds:
  - NUM_CH;
  - register offsets REG_PERIOD/REG_VOLUME/REG_WIDTH/REG_DURATION;
  - reset constants PERIOD_RST = 16'h377D, VOLUME_RST = 0, WIDTH_RST = 3;
  - a scanner state enum.
- Natural sub-module: sound_tick_prescaler, a counter that emits the tick pulse.
- Scanner and register file stay in sound_sequencer.

Test Plan:
- Reset: assert reset, release -> every period_out field = 14205, volume = 0, width = 3, done = 0, busy = 0.
- Write decode: write addr=4'h5 data=16'h001F -> volume_out[9:5] = 31 next cycle, other channels unchanged. Write addr=4'h2 data=7 -> width_out[2:0] = 7.
- Duration expiry (TICK_DIV = 8): ch2 volume = 20, duration = 3 -> after 3 ticks, volume_out[14:10] = 0 and done[2] = 1. done_clr = 4'b0100 -> done[2] = 0.
- Collision: issue a ch1 duration write in the SCAN1 cycle of a tick -> ch1 duration equals the written value, not value-1. ch1 volume is still handled by the scan.
- Envelope (SOUND_ENVELOPE_EN): ch0 volume = 4, decay_rate = 2, duration = 0 -> volume steps 4, 3, 2, 1, 0 every 2 ticks, then holds at 0. Without the macro, volume stays 4.
- Reset mid-scan: assert reset during SCAN2 -> IDLE and all reset values on the next cycle.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound sequencer.
// Holds the channel count, register offsets, reset values and scanner states.
package sound_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] REG_PERIOD   = 2'd0;
    localparam logic [1:0] REG_VOLUME   = 2'd1;
    localparam logic [1:0] REG_WIDTH    = 2'd2;
    localparam logic [1:0] REG_DURATION = 2'd3;

    localparam logic [15:0] PERIOD_RST = 16'h377D;
    localparam logic [4:0]  VOLUME_RST = 5'd0;
    localparam logic [2:0]  WIDTH_RST  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN0,
        ST_SCAN1,
        ST_SCAN2,
        ST_SCAN3
    } scan_state_t;

endpackage

// File: rtl/sound_tick_prescaler.sv
// Free-running prescaler producing the sequencer tick.
// Ports: clk, reset (sync, active-high), tick (one-cycle pulse every TICK_DIV clocks).
module sound_tick_prescaler #(
    parameter int TICK_DIV = 800
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = (cnt == 16'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/sound_sequencer.sv
// CPU-facing register file and note sequencer for the 4-channel sound generator.
// Ports: clk, reset (sync, active-high); wr_en/addr/wr_data register writes;
// done_clr sticky clears; period_out/volume_out/width_out packed per channel;
// done sticky expiry flags; busy high during a tick scan.
// Build option: SOUND_ENVELOPE_EN enables per-channel volume decay.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_DIV = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [15:0] wr_data,
    input  logic [3:0]  done_clr,
    output logic [63:0] period_out,
    output logic [19:0] volume_out,
    output logic [11:0] width_out,
    output logic [3:0]  done,
    output logic        busy
);

    logic [15:0] period_q [NUM_CH];
    logic [4:0]  vol_q    [NUM_CH];
    logic [2:0]  width_q  [NUM_CH];
    logic [15:0] dur_q    [NUM_CH];
    logic [4:0]  rate_q   [NUM_CH];
    logic [4:0]  dcnt_q   [NUM_CH];
    logic [3:0]  done_q;

    scan_state_t state;
    logic        busy_q;
    logic        tick;

    sound_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state  <= ST_SCAN0;
                        busy_q <= 1'b1;
                    end
                end
                ST_SCAN0: state <= ST_SCAN1;
                ST_SCAN1: state <= ST_SCAN2;
                ST_SCAN2: state <= ST_SCAN3;
                ST_SCAN3: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    logic       scan_act;
    logic [1:0] scan_ch;

    always_comb begin
        scan_act = 1'b1;
        scan_ch  = 2'd0;
        unique case (state)
            ST_SCAN0: scan_ch = 2'd0;
            ST_SCAN1: scan_ch = 2'd1;
            ST_SCAN2: scan_ch = 2'd2;
            ST_SCAN3: scan_ch = 2'd3;
            default:  scan_act = 1'b0;
        endcase
    end

    // Single shared datapath: operands are muxed from the channel
    // currently being scanned and written back to that channel only.
    logic [15:0] dur_sel, dur_nx;
    logic [4:0]  vol_sel, vol_nx;
    logic [4:0]  rate_sel;
    logic [4:0]  dcnt_sel, dcnt_nx;
    logic        expire;

    assign dur_sel  = dur_q[scan_ch];
    assign vol_sel  = vol_q[scan_ch];
    assign rate_sel = rate_q[scan_ch];
    assign dcnt_sel = dcnt_q[scan_ch];

    always_comb begin
        dur_nx  = dur_sel;
        vol_nx  = vol_sel;
        dcnt_nx = dcnt_sel;
        expire  = 1'b0;
        // Decay counter runs regardless; it only touches volume when
        // the envelope is built in.
        if (rate_sel != 5'd0) begin
            if (dcnt_sel <= 5'd1) begin
                dcnt_nx = rate_sel;
`ifdef SOUND_ENVELOPE_EN
                if (vol_sel != 5'd0)
                    vol_nx = vol_sel - 5'd1;
`endif
            end else begin
                dcnt_nx = dcnt_sel - 5'd1;
            end
        end
        if (dur_sel == 16'd1) begin
            dur_nx = 16'd0;
            vol_nx = 5'd0;
            expire = 1'b1;
        end else if (dur_sel != 16'd0) begin
            dur_nx = dur_sel - 16'd1;
        end
    end

    logic [1:0] wr_ch;
    logic [3:0] set_mask;
    logic [3:0] done_d;

    assign wr_ch = addr[3:2];

    always_comb begin
        set_mask = '0;
        if (scan_act && expire)
            set_mask = 4'b0001 << scan_ch;
        done_d = (done_q & ~done_clr) | set_mask;
        if (wr_en && addr[1:0] == REG_DURATION)
            done_d[wr_ch] = 1'b0;
    end

    // Scan results land first; a write to the same channel then
    // overrides only the register it addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= PERIOD_RST;
                vol_q[i]    <= VOLUME_RST;
                width_q[i]  <= WIDTH_RST;
                dur_q[i]    <= '0;
                rate_q[i]   <= '0;
                dcnt_q[i]   <= '0;
            end
            done_q <= '0;
        end else begin
            if (scan_act) begin
                dur_q[scan_ch]  <= dur_nx;
                vol_q[scan_ch]  <= vol_nx;
                dcnt_q[scan_ch] <= dcnt_nx;
            end
            if (wr_en) begin
                unique case (addr[1:0])
                    REG_PERIOD: period_q[wr_ch] <= wr_data;
                    REG_VOLUME: begin
                        vol_q[wr_ch]  <= wr_data[4:0];
                        rate_q[wr_ch] <= wr_data[12:8];
                        dcnt_q[wr_ch] <= wr_data[12:8];
                    end
                    REG_WIDTH:    width_q[wr_ch] <= wr_data[2:0];
                    REG_DURATION: dur_q[wr_ch]   <= wr_data;
                    default: ;
                endcase
            end
            done_q <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign period_out[16*g +: 16] = period_q[g];
        assign volume_out[5*g +: 5]   = vol_q[g];
        assign width_out[3*g +: 3]    = width_q[g];
    end

    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer with a cycle-indexed reference model.
// Directed steps followed by a randomized write phase; every cycle is compared.
module tb_sound_sequencer;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  addr;
    logic [15:0] wr_data;
    logic [3:0]  done_clr;
    logic [63:0] period_out;
    logic [19:0] volume_out;
    logic [11:0] width_out;
    logic [3:0]  done;
    logic        busy;

    always #5 clk = ~clk;

    sound_sequencer #(
        .TICK_DIV(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .done_clr  (done_clr),
        .period_out(period_out),
        .volume_out(volume_out),
        .width_out (width_out),
        .done      (done),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int m_period[4];
    int m_vol[4];
    int m_width[4];
    int m_dur[4];
    int m_rate[4];
    int m_dcnt[4];
    logic [3:0] m_done;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel n is serviced in cycle k*D+n (k >= 1) counted from reset.
    task automatic model_update();
        logic [3:0] nd;
        int n;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_period[i] = 14205;
                m_vol[i]    = 0;
                m_width[i]  = 3;
                m_dur[i]    = 0;
                m_rate[i]   = 0;
                m_dcnt[i]   = 0;
            end
            m_done = '0;
            cyc    = 0;
        end else begin
            nd = m_done & ~done_clr;
            if (cyc >= D && cyc % D < 4) begin
                n = cyc % D;
`ifdef SOUND_ENVELOPE_EN
                if (m_rate[n] != 0) begin
                    if (m_dcnt[n] > 0) m_dcnt[n]--;
                    if (m_dcnt[n] == 0) begin
                        m_dcnt[n] = m_rate[n];
                        if (m_vol[n] > 0) m_vol[n]--;
                    end
                end
`endif
                if (m_dur[n] == 1) begin
                    m_dur[n] = 0;
                    m_vol[n] = 0;
                    nd[n]    = 1'b1;
                end else if (m_dur[n] > 1) begin
                    m_dur[n]--;
                end
            end
            if (wr_en) begin
                n = int'(addr[3:2]);
                case (addr[1:0])
                    2'd0: m_period[n] = int'(wr_data);
                    2'd1: begin
                        m_vol[n]  = int'(wr_data[4:0]);
                        m_rate[n] = int'(wr_data[12:8]);
                        m_dcnt[n] = m_rate[n];
                    end
                    2'd2: m_width[n] = int'(wr_data[2:0]);
                    default: begin
                        m_dur[n] = int'(wr_data);
                        nd[n]    = 1'b0;
                    end
                endcase
            end
            m_done = nd;
            cyc++;
        end
    endtask

    task automatic check_all();
        logic [63:0] ep;
        logic [19:0] ev;
        logic [11:0] ew;
        for (int i = 0; i < 4; i++) begin
            ep[16*i +: 16] = 16'(m_period[i]);
            ev[5*i +: 5]   = 5'(m_vol[i]);
            ew[3*i +: 3]   = 3'(m_width[i]);
        end
        chk("period", period_out, ep);
        chk("volume", volume_out, ev);
        chk("width", width_out, ew);
        chk("done", done, m_done);
        chk("busy", busy, (cyc >= D && cyc % D < 4));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_phase(input int p);
        int guard = 0;
        while (!(cyc >= D && cyc % D == p) && guard < 4 * D) begin
            step();
            guard++;
        end
        chk("phase_reached", (guard < 4 * D), 1);
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        addr     = '0;
        wr_data  = '0;
        done_clr = '0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        chk("rst_period0", period_out[15:0], 16'h377D);
        chk("rst_period3", period_out[63:48], 16'h377D);
        chk("rst_width", width_out, 12'o3333);
        chk("rst_busy", busy, 0);

        wr(4'h5, 16'h001F);
        chk("wr_vol1", volume_out[9:5], 31);
        chk("wr_vol_oth", {volume_out[19:10], volume_out[4:0]}, 0);
        wr(4'h2, 16'h0007);
        chk("wr_width0", width_out[2:0], 7);
        wr(4'hC, 16'hBEEF);
        chk("wr_period3", period_out[63:48], 16'hBEEF);

        wr(4'h9, 16'd20);
        wr(4'hB, 16'd3);
        idle(4 * D);
        chk("exp_vol2", volume_out[14:10], 0);
        chk("exp_done2", done[2], 1);
        done_clr = 4'b0100;
        step();
        done_clr = 4'b0000;
        chk("clr_done2", done[2], 0);

        wait_phase(5);
        wr(4'h5, 16'd10);
        wr(4'h7, 16'd1);
        wait_phase(1);
        wr(4'h7, 16'd9);
        chk("col_vol1", volume_out[9:5], 0);
        chk("col_done1", done[1], 0);
        idle(8 * D);
        chk("col_done_8", done[1], 0);
        idle(D);
        chk("col_done_9", done[1], 1);

        wr(4'h1, 16'h0204);
        idle(12 * D);
`ifdef SOUND_ENVELOPE_EN
        chk("env_final", volume_out[4:0], 0);
`else
        chk("env_final", volume_out[4:0], 4);
`endif

        repeat (400) begin
            wr_en   = 1'($urandom_range(0, 1));
            addr    = 4'($urandom);
            wr_data = 16'($urandom);
            if (addr[1:0] == 2'd3)
                wr_data = 16'($urandom_range(0, 6));
            if (addr[1:0] == 2'd1)
                wr_data[12:8] = 5'($urandom_range(0, 3));
            done_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            step();
        end
        wr_en    = 1'b0;
        done_clr = 4'b0000;

        wait_phase(2);
        chk("mid_busy_pre", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_period", period_out, {4{16'h377D}});
        chk("mid_volume", volume_out, 0);
        chk("mid_done", done, 0);
        idle(2 * D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
